// File: rtl/relobi_r_other_ecc_pipe.sv
// relobi_r_other_ecc_pipe
//   Registered, handshaked R-channel "other"-field ECC encoder. The Hsiao
//   check bits over {rid, err?, exokay?, ruser?, rchk?} are computed on the
//   input side and carried with the beat through NumStages (0..3) elastic
//   register stages. The payload is passed through unprotected.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rvalid_i / rready_o      upstream handshake
//   err_i, rid_i,
//   r_optional_i, payload_i  input beat ({exokay, ruser, rchk} packed MSB->LSB)
//   rvalid_o / rready_i      downstream handshake
//   err_o, rid_o,
//   r_optional_o, payload_o  output beat
//   other_ecc_o              check bits of the beat on the outputs
//   occupancy_o              number of stages holding a beat
//   ecc_mismatch_o           sticky output-side re-encode mismatch
//
// Build option
//   RELOBI_R_OTHER_ECC_SELFCHECK_EN: re-encode the output fields and flag any
//   disagreement with other_ecc_o. Without it ecc_mismatch_o is tied to 0.

package relobi_r_other_ecc_pkg;

    // Smallest SEC-DED check-bit count for a given data width.
    function automatic int unsigned min_ecc(input int unsigned data_width);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (r + data_width + 1)) r++;
        return r + 1;
    endfunction

    // Hsiao column idx: idx-th odd-weight (>=3) value in ascending order.
    function automatic int unsigned hsiao_col(input int unsigned ecc_width,
                                              input int unsigned idx);
        int unsigned n;
        int unsigned col;
        int          w;
        n   = 0;
        col = 0;
        for (int unsigned v = 0; v < (32'd1 << ecc_width); v++) begin
            w = $countones(v);
            if (w >= 3 && w[0] && n <= idx) begin
                if (n == idx) col = v;
                n++;
            end
        end
        return col;
    endfunction

    function automatic int unsigned hsiao_num_cols(input int unsigned ecc_width);
        int unsigned n;
        int          w;
        n = 0;
        for (int unsigned v = 0; v < (32'd1 << ecc_width); v++) begin
            w = $countones(v);
            if (w >= 3 && w[0]) n++;
        end
        return n;
    endfunction

endpackage

// Hsiao encoder: o_code = {check bits, data}.
module relobi_r_other_ecc_enc #(
    parameter int unsigned DataWidth = 5,
    parameter int unsigned EccWidth  = 5
) (
    input  logic [DataWidth-1:0]          i_data,
    output logic [EccWidth+DataWidth-1:0] o_code
);
    logic [EccWidth-1:0] w_cols [DataWidth];
    logic [EccWidth-1:0] w_check;

    for (genvar g = 0; g < DataWidth; g++) begin : g_col
        localparam logic [EccWidth-1:0] Col =
            EccWidth'(relobi_r_other_ecc_pkg::hsiao_col(EccWidth, g));
        assign w_cols[g] = i_data[g] ? Col : '0;
    end

    always_comb begin
        w_check = '0;
        for (int i = 0; i < int'(DataWidth); i++) w_check = w_check ^ w_cols[i];
    end

    assign o_code = {w_check, i_data};
endmodule

module relobi_r_other_ecc_pipe #(
    parameter int unsigned IdWidth      = 4,
    parameter bit          UseAtop      = 1'b1,
    parameter int unsigned RUserWidth   = 0,
    parameter int unsigned RChkWidth    = 0,
    parameter int unsigned PayloadWidth = 32,
    parameter bit          IncludeErr   = 1'b0,
    parameter int unsigned NumStages    = 1,
    localparam int unsigned OptUsed       = 32'(UseAtop) + RUserWidth + RChkWidth,
    localparam int unsigned OptWidth      = (OptUsed == 0) ? 1 : OptUsed,
    localparam int unsigned PreWidth      = IdWidth + 32'(IncludeErr) + OptUsed,
    localparam int unsigned OtherEccWidth = relobi_r_other_ecc_pkg::min_ecc(PreWidth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    input  logic                     err_i,
    input  logic [IdWidth-1:0]       rid_i,
    input  logic [OptWidth-1:0]      r_optional_i,
    input  logic [PayloadWidth-1:0]  payload_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic                     err_o,
    output logic [IdWidth-1:0]       rid_o,
    output logic [OptWidth-1:0]      r_optional_o,
    output logic [PayloadWidth-1:0]  payload_o,
    output logic [OtherEccWidth-1:0] other_ecc_o,
    output logic [1:0]               occupancy_o,
    output logic                     ecc_mismatch_o
);
    localparam int unsigned BeatWidth = 1 + IdWidth + OptWidth + PayloadWidth + OtherEccWidth;

    if (NumStages > 3) begin : g_bad_num_stages
        $error("relobi_r_other_ecc_pipe: NumStages must be in 0..3");
    end
    if (relobi_r_other_ecc_pkg::hsiao_num_cols(OtherEccWidth) < PreWidth) begin : g_bad_ecc_width
        $error("relobi_r_other_ecc_pipe: OtherEccWidth too small for PreWidth");
    end

    // {rid, err (if IncludeErr), optional fields}, MSB->LSB.
    function automatic logic [PreWidth-1:0] pack_pre(input logic [IdWidth-1:0]  rid,
                                                     input logic                err,
                                                     input logic [OptWidth-1:0] opt);
        logic [PreWidth-1:0] w;
        w = '0;
        for (int i = 0; i < int'(OptUsed); i++) w[i] = opt[i];
        if (IncludeErr) w[OptUsed] = err;
        for (int i = 0; i < int'(IdWidth); i++) w[PreWidth - IdWidth + i] = rid[i];
        return w;
    endfunction

    logic [PreWidth-1:0]               w_pre;
    logic [OtherEccWidth+PreWidth-1:0] w_code;
    logic [BeatWidth-1:0]              w_beat_in;
    logic [BeatWidth-1:0]              w_beat_out;
    logic                              w_unused_data;

    assign w_pre = pack_pre(rid_i, err_i, r_optional_i);

    relobi_r_other_ecc_enc #(
        .DataWidth (PreWidth),
        .EccWidth  (OtherEccWidth)
    ) u_enc (
        .i_data (w_pre),
        .o_code (w_code)
    );

    // Only the check bits travel; the data half of the codeword is dropped.
    assign w_unused_data = ^w_code[PreWidth-1:0];
    assign w_beat_in     = {err_i, rid_i, r_optional_i, payload_i, w_code[PreWidth +: OtherEccWidth]};

    if (NumStages == 0) begin : g_bypass
        assign w_beat_out  = w_beat_in;
        assign rvalid_o    = rvalid_i;
        assign rready_o    = rready_i;
        assign occupancy_o = 2'd0;
    end else begin : g_pipe
        logic [NumStages-1:0] r_valid;
        logic [BeatWidth-1:0] r_data [NumStages];
        logic [NumStages:0]   w_ready;
        logic [NumStages-1:0] w_in_valid;
        logic [BeatWidth-1:0] w_in_data [NumStages];

        // A stage can take a beat if it is empty or its beat leaves this cycle.
        always_comb begin
            w_ready            = '0;
            w_ready[NumStages] = rready_i;
            for (int s = int'(NumStages) - 1; s >= 0; s--) begin
                w_ready[s] = w_ready[s+1] || !r_valid[s];
            end
        end

        always_comb begin
            w_in_valid    = '0;
            w_in_valid[0] = rvalid_i;
            w_in_data[0]  = w_beat_in;
            for (int s = 1; s < int'(NumStages); s++) begin
                w_in_valid[s] = r_valid[s-1];
                w_in_data[s]  = r_data[s-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= '0;
                for (int s = 0; s < int'(NumStages); s++) r_data[s] <= '0;
            end else begin
                for (int s = 0; s < int'(NumStages); s++) begin
                    if (w_in_valid[s] && w_ready[s]) begin
                        r_valid[s] <= 1'b1;
                        r_data[s]  <= w_in_data[s];
                    end else if (w_ready[s+1]) begin
                        r_valid[s] <= 1'b0;
                    end
                end
            end
        end

        assign w_beat_out  = r_data[NumStages-1];
        assign rvalid_o    = r_valid[NumStages-1];
        assign rready_o    = w_ready[0];
        assign occupancy_o = 2'($countones(r_valid));
    end

    assign {err_o, rid_o, r_optional_o, payload_o, other_ecc_o} = w_beat_out;

`ifdef RELOBI_R_OTHER_ECC_SELFCHECK_EN
    logic [PreWidth-1:0]               w_pre_out;
    logic [OtherEccWidth+PreWidth-1:0] w_code_out;
    logic                              w_unused_chk_data;
    logic                              w_ecc_bad;
    logic                              r_mismatch;

    assign w_pre_out = pack_pre(rid_o, err_o, r_optional_o);

    relobi_r_other_ecc_enc #(
        .DataWidth (PreWidth),
        .EccWidth  (OtherEccWidth)
    ) u_enc_chk (
        .i_data (w_pre_out),
        .o_code (w_code_out)
    );

    assign w_unused_chk_data = ^w_code_out[PreWidth-1:0];
    assign w_ecc_bad = rvalid_o && (w_code_out[PreWidth +: OtherEccWidth] != other_ecc_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        r_mismatch <= 1'b0;
        else if (w_ecc_bad) r_mismatch <= 1'b1;
    end

    assign ecc_mismatch_o = r_mismatch;

    a_other_ecc_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_ecc_bad);
`else
    assign ecc_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_relobi_r_other_ecc_pipe.sv
// Directed bench for relobi_r_other_ecc_pipe.
//   u_dut1: IdWidth=4, UseAtop=1, NumStages=1, IncludeErr=0 (pre-word {rid, exokay})
//   u_dut2: IdWidth=4, UseAtop=1, NumStages=2, IncludeErr=1 (pre-word {rid, err, exokay})
// Expected ECC values are hand-computed from the Hsiao columns for 5 check
// bits: d0=07 d1=0B d2=0D d3=0E d4=13 d5=15.

module tb_relobi_r_other_ecc_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // dut1 signals
    logic       a_rvalid, a_rready_o, a_err, a_rvalid_o, a_rready_i, a_err_o, a_mm;
    logic [3:0] a_rid, a_rid_o;
    logic [0:0] a_opt, a_opt_o;
    logic [7:0] a_pay, a_pay_o;
    logic [4:0] a_ecc;
    logic [1:0] a_occ;

    // dut2 signals
    logic       b_rvalid, b_rready_o, b_err, b_rvalid_o, b_rready_i, b_err_o, b_mm;
    logic [3:0] b_rid, b_rid_o;
    logic [0:0] b_opt, b_opt_o;
    logic [7:0] b_pay, b_pay_o;
    logic [4:0] b_ecc;
    logic [1:0] b_occ;

    relobi_r_other_ecc_pipe #(
        .IdWidth(4), .UseAtop(1'b1), .RUserWidth(0), .RChkWidth(0),
        .PayloadWidth(8), .IncludeErr(1'b0), .NumStages(1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .rvalid_i(a_rvalid), .rready_o(a_rready_o),
        .err_i(a_err), .rid_i(a_rid), .r_optional_i(a_opt), .payload_i(a_pay),
        .rvalid_o(a_rvalid_o), .rready_i(a_rready_i),
        .err_o(a_err_o), .rid_o(a_rid_o), .r_optional_o(a_opt_o), .payload_o(a_pay_o),
        .other_ecc_o(a_ecc), .occupancy_o(a_occ), .ecc_mismatch_o(a_mm)
    );

    relobi_r_other_ecc_pipe #(
        .IdWidth(4), .UseAtop(1'b1), .RUserWidth(0), .RChkWidth(0),
        .PayloadWidth(8), .IncludeErr(1'b1), .NumStages(2)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .rvalid_i(b_rvalid), .rready_o(b_rready_o),
        .err_i(b_err), .rid_i(b_rid), .r_optional_i(b_opt), .payload_i(b_pay),
        .rvalid_o(b_rvalid_o), .rready_i(b_rready_i),
        .err_o(b_err_o), .rid_o(b_rid_o), .r_optional_o(b_opt_o), .payload_o(b_pay_o),
        .other_ecc_o(b_ecc), .occupancy_o(b_occ), .ecc_mismatch_o(b_mm)
    );

    // dut2 beats rid=i, err=0, exokay=0
    logic [4:0] ecc_stream [8] = '{5'h00, 5'h0D, 5'h0E, 5'h03, 5'h13, 5'h1E, 5'h1D, 5'h10};
    logic [3:0] bp_rid [3]     = '{4'h8, 4'h9, 4'hA};
    logic [4:0] bp_ecc [3]     = '{5'h15, 5'h18, 5'h1B};
    logic [3:0] got_rid [3];
    logic [4:0] got_ecc [3];
    int         idx;
    int         n_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [3:0] rid, input logic err,
                           input logic exokay, input logic [7:0] pay);
        a_rvalid = v; a_rid = rid; a_err = err; a_opt = exokay; a_pay = pay;
    endtask

    task automatic drive_b(input logic v, input logic [3:0] rid, input logic err,
                           input logic [7:0] pay);
        b_rvalid = v; b_rid = rid; b_err = err; b_opt = 1'b0; b_pay = pay;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
        drive_b(1'b0, 4'h0, 1'b0, 8'h00);
        a_rready_i = 1'b1;
        b_rready_i = 1'b1;

        // reset state
        #3;
        check("rst_a_rvalid", a_rvalid_o, 0);
        check("rst_a_ecc", a_ecc, 0);
        check("rst_a_occ", a_occ, 0);
        check("rst_a_rready", a_rready_o, 1);
        check("rst_b_rvalid", b_rvalid_o, 0);
        check("rst_b_occ", b_occ, 0);
        check("rst_b_rready", b_rready_o, 1);
        check("rst_b_mm", b_mm, 0);
        #5 rst_n = 1'b1;
        tick();

        // single beat, one stage
        drive_a(1'b1, 4'hA, 1'b0, 1'b1, 8'h5A);
        #1 check("a_in_ready", a_rready_o, 1);
        tick();
        drive_a(1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
        check("a_one_rvalid", a_rvalid_o, 1);
        check("a_one_rid", a_rid_o, 4'hA);
        check("a_one_exokay", a_opt_o, 1);
        check("a_one_pay", a_pay_o, 8'h5A);
        check("a_one_ecc", a_ecc, 5'h19);
        check("a_one_occ", a_occ, 1);
        tick();
        check("a_drain_rvalid", a_rvalid_o, 0);
        check("a_drain_occ", a_occ, 0);

        // err is not covered when IncludeErr=0
        drive_a(1'b1, 4'h3, 1'b0, 1'b0, 8'h01);
        tick();
        check("a_err0_ecc", a_ecc, 5'h06);
        check("a_err0_err", a_err_o, 0);
        drive_a(1'b1, 4'h3, 1'b1, 1'b0, 8'h02);
        tick();
        check("a_err1_ecc", a_ecc, 5'h06);
        check("a_err1_err", a_err_o, 1);
        check("a_err1_pay", a_pay_o, 8'h02);
        drive_a(1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
        tick();

        // two stages, 8 back-to-back beats
        for (int i = 0; i < 8; i++) begin
            drive_b(1'b1, 4'(i), 1'b0, 8'(8'h10 + i));
            #1 check("b_stream_rready", b_rready_o, 1);
            tick();
            check("b_stream_occ", b_occ, (i == 0) ? 1 : 2);
            if (i == 0) begin
                check("b_first_latency", b_rvalid_o, 0);
            end else begin
                check("b_stream_rvalid", b_rvalid_o, 1);
                check("b_stream_rid", b_rid_o, i - 1);
                check("b_stream_ecc", b_ecc, ecc_stream[i-1]);
                check("b_stream_pay", b_pay_o, 8'h10 + i - 1);
            end
        end
        drive_b(1'b0, 4'h0, 1'b0, 8'h00);
        tick();
        check("b_last_rid", b_rid_o, 4'h7);
        check("b_last_ecc", b_ecc, 5'h10);
        check("b_last_occ", b_occ, 1);
        tick();
        check("b_empty_rvalid", b_rvalid_o, 0);
        check("b_empty_occ", b_occ, 0);

        // err is covered when IncludeErr=1
        drive_b(1'b1, 4'h0, 1'b0, 8'hE0);
        tick();
        drive_b(1'b1, 4'h0, 1'b1, 8'hE1);
        tick();
        check("b_err0_ecc", b_ecc, 5'h00);
        check("b_err0_err", b_err_o, 0);
        drive_b(1'b0, 4'h0, 1'b0, 8'h00);
        tick();
        check("b_err1_ecc", b_ecc, 5'h0B);
        check("b_err1_err", b_err_o, 1);
        tick();

        // backpressure: 3 beats offered, output stalled for 5 cycles
        idx   = 0;
        n_got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            b_rready_i = (cyc >= 5);
            if (idx < 3) drive_b(1'b1, bp_rid[idx], 1'b0, 8'(8'hB0 + idx));
            else         drive_b(1'b0, 4'h0, 1'b0, 8'h00);
            #1;
            if (cyc == 3 || cyc == 4) begin
                check("bp_stall_rvalid", b_rvalid_o, 1);
                check("bp_stall_rid", b_rid_o, 4'h8);
                check("bp_stall_ecc", b_ecc, 5'h15);
                check("bp_stall_occ", b_occ, 2);
                check("bp_stall_rready", b_rready_o, 0);
                check("bp_stall_accepts", idx, 2);
            end
            if (b_rvalid_o && b_rready_i) begin
                if (n_got < 3) begin
                    got_rid[n_got] = b_rid_o;
                    got_ecc[n_got] = b_ecc;
                end
                n_got++;
            end
            if (b_rvalid && b_rready_o) idx++;
            tick();
        end
        check("bp_count", n_got, 3);
        for (int k = 0; k < 3; k++) begin
            check("bp_order_rid", got_rid[k], bp_rid[k]);
            check("bp_order_ecc", got_ecc[k], bp_ecc[k]);
        end
        check("bp_final_occ", b_occ, 0);

        // reset with a full pipeline
        b_rready_i = 1'b0;
        drive_b(1'b1, 4'h5, 1'b0, 8'h55);
        tick();
        drive_b(1'b1, 4'h6, 1'b0, 8'h66);
        tick();
        drive_b(1'b0, 4'h0, 1'b0, 8'h00);
        #1;
        check("rstmid_pre_occ", b_occ, 2);
        check("rstmid_pre_rvalid", b_rvalid_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_rvalid", b_rvalid_o, 0);
        check("rstmid_occ", b_occ, 0);
        check("rstmid_ecc", b_ecc, 0);
        check("rstmid_rready", b_rready_o, 1);
        #1 rst_n = 1'b1;
        b_rready_i = 1'b1;
        tick();
        drive_b(1'b1, 4'h7, 1'b0, 8'h77);
        tick();
        drive_b(1'b0, 4'h0, 1'b0, 8'h00);
        check("post_rst_wait", b_rvalid_o, 0);
        tick();
        check("post_rst_rvalid", b_rvalid_o, 1);
        check("post_rst_rid", b_rid_o, 4'h7);
        check("post_rst_ecc", b_ecc, 5'h10);
        check("post_rst_pay", b_pay_o, 8'h77);
        tick();
        check("post_rst_drain", b_rvalid_o, 0);

`ifdef RELOBI_R_OTHER_ECC_SELFCHECK_EN
        a_rready_i = 1'b0;
        drive_a(1'b1, 4'hA, 1'b0, 1'b1, 8'h5A);
        tick();
        drive_a(1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
        check("sc_clean", a_mm, 0);
        force u_dut1.g_pipe.r_data[0] = {1'b0, 4'hA, 1'b1, 8'h5A, 5'h18};
        tick();
        tick();
        check("sc_flag", a_mm, 1);
        release u_dut1.g_pipe.r_data[0];
        a_rready_i = 1'b1;
        tick();
        drive_a(1'b1, 4'h3, 1'b0, 1'b0, 8'h01);
        tick();
        drive_a(1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
        tick();
        check("sc_sticky", a_mm, 1);
`else
        check("a_mm_tied", a_mm, 0);
        check("b_mm_tied", b_mm, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/relobi_r_other_ecc_pipe.md
Name: relobi_r_other_ecc_pipe

Overview:
- Registered, handshaked successor to the combinational R-channel "other"-field encoder.
- Accepts an OBI R beat: rid, optional err, r_optional fields (exokay/ruser/rchk), plus an opaque payload such as rdata.
- Computes the Hsiao ECC over the sideband fields, then carries beat and ECC through a configurable chain of elastic pipeline registers.
- Sits at relOBI subordinate-side R-channel outputs, where timing closure needs the ECC cut from the response path.

Parameters:
- Cfg, obi_pkg::ObiDefaultConfig: bus configuration (IdWidth, OptionalCfg).
- r_optional_t, logic: struct carrying exokay/ruser/rchk as enabled by Cfg.
- payload_t, logic: opaque pass-through payload (not ECC-covered here).
- IncludeErr, 1'b0: 1 adds the err bit to the ECC-covered pre-encode word.
- NumStages, 1: number of elastic register stages, legal range 0..3. 0 = combinational pass-through.
- OtherEccWidth, derived: Hsiao check-bit count for PreWidth = relobi_pkg::relobi_r_other_width(Cfg) + IncludeErr. Elaboration assertion checks it against the hsiao_ecc_enc output width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rvalid_i  in  1  input beat valid
- rready_o  out  1  input beat accepted when rvalid_i && rready_o
- err_i  in  1  response error
- rid_i  in  Cfg.IdWidth  response ID
- r_optional_i  in  r_optional_t  optional R fields
- payload_i  in  payload_t  pass-through data
- rvalid_o  out  1  output beat valid
- rready_i  in  1  downstream ready
- err_o / rid_o / r_optional_o / payload_o  out  as inputs  registered copies of the input fields
- other_ecc_o  out  OtherEccWidth  check bits for the beat on the outputs
- occupancy_o  out  2  number of stages currently holding a beat (0..NumStages)
- ecc_mismatch_o  out  1  sticky self-check flag (see Optional Feature)

Behaviour:
- Pre-encode word packing, MSB→LSB:
  - rid
  - err (if IncludeErr)
  - exokay (if Cfg.OptionalCfg.UseAtop)
  - ruser (if RUserWidth>0)
  - rchk (if RChkWidth>0)
- Absent fields take zero width.
- Encoder output = {check bits, data}. Only the check bits are kept; the data bits are discarded.
- Encoding is combinational on the input side, before stage 1. Each stage stores {err, rid, r_optional, payload, ecc, valid}.
- Stage rule (pipeline register, full throughput):
  - in_ready = out_ready || !valid_q.
  - On in_valid && in_ready: load the stage, valid_q ← 1.
  - Else if out_ready: valid_q ← 0.
- Latency: NumStages cycles from acceptance to rvalid_o, with no bubble insertion. Sustained 1 beat/cycle when rready_i is held 1.
- Backpressure:
  - While rvalid_o && !rready_i, all outputs are held stable.
  - rvalid_o never drops without a handshake.
- Full pipeline with rready_i=0 → rready_o=0.
- Simultaneous accept and drain on a full stage → the stage loads the new beat; no loss, no duplication.
- NumStages=0:
  - rready_o = rready_i, rvalid_o = rvalid_i.
  - Outputs are combinational; occupancy_o = 0.
- Reset (async assert, sync deassert expected):
  - all valid_q ← 0; data registers ← 0.
  - rvalid_o=0, other_ecc_o=0, occupancy_o=0, ecc_mismatch_o=0.
  - rready_o=1 when NumStages>0.
- Reset mid-transfer drops in-flight beats silently.
- occupancy_o = popcount of the stage valid bits, updated the cycle after each handshake.
- Data registers are enabled only on load; no toggling on idle cycles.

Optional Feature:
- Macro: RELOBI_R_OTHER_ECC_SELFCHECK_EN.
- Defined:
  - A second hsiao_ecc_enc re-encodes the output-side fields; the result is compared with other_ecc_o whenever rvalid_o=1.
  - Any mismatch sets ecc_mismatch_o, which stays 1 until reset.
  - Also instantiates an assertion that flags the mismatch in simulation.
- Undefined: ecc_mismatch_o tied to 0; no second encoder.

Test Plan:
- Cfg IdWidth=4, UseAtop=1, NumStages=1. Send rid=4'hA, exokay=1, rready_i=1 → rvalid_o the next cycle, rid_o=4'hA, other_ecc_o equal to the golden Hsiao model of 5'b1010_1.
- NumStages=2, 8 back-to-back beats, rready_i=1 → outputs in order, first beat 2 cycles after the first acceptance, one beat per cycle, occupancy_o=2 at steady state.
- NumStages=2, rready_i=0 while 3 beats are offered → rready_o=0 after 2 accepts, occupancy_o=2, outputs stable. Release rready_i → all 3 beats delivered, none lost or duplicated.
- IncludeErr=1, rid=0, err toggles 0→1 → other_ecc_o differs between the two beats. IncludeErr=0 → identical ECC.
- Assert rst_ni low with occupancy_o=2 → rvalid_o=0 and occupancy_o=0 immediately. After release, the first new beat appears normally.
- With SELFCHECK_EN, force one stored ecc bit via the bench → ecc_mismatch_o=1 and it stays set across later beats until reset.
